// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: request opcodes, FSM states, SP constants.
// STACK_SAVE_FLAGS_EN adds the flag save/restore states used by INT/RTI.
package stack_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_INT  = 3'd4;
  localparam logic [2:0] OP_RTI  = 3'd5;

  localparam logic [7:0] SP_EMPTY = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PC,
`ifdef STACK_SAVE_FLAGS_EN
    S_WR_FL,
    S_RD_FL,
`endif
    S_RD,
    S_RD_W
  } state_e;

endpackage

// File: rtl/stack_addr_unit.sv
// Combinational stack step: address, next SP and overflow/underflow for one push or pop.
module stack_addr_unit
  import stack_pkg::*;
(
  input  logic [7:0] sp,
  input  logic       pop,
  output logic [7:0] addr,
  output logic [7:0] sp_next,
  output logic       err
);

  // Push is post-decrement (write at sp), pop is pre-increment (read at sp+1).
  always_comb begin
    if (pop) begin
      addr    = sp + 8'd1;
      sp_next = sp + 8'd1;
      err     = (sp == SP_EMPTY);
    end else begin
      addr    = sp;
      sp_next = sp - 8'd1;
      err     = (sp == 8'h00);
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle PUSH/POP/CALL/RET/INT/RTI controller owning the stack pointer.
// Define STACK_SAVE_FLAGS_EN to save/restore the CCR on INT/RTI.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  output logic       req_ready,
  input  logic [7:0] push_data,
  input  logic [7:0] pc_in,
  input  logic [7:0] target_pc,
  input  logic [7:0] int_vector,
  input  logic [3:0] flags_in,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       sp_we,
  output logic [7:0] sp_wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] pop_data,
  output logic       pc_load,
  output logic [7:0] pc_value,
  output logic       flags_load,
  output logic [3:0] flags_out,
  output logic       stack_err
);

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] sp_q, sp_d;
  logic       err_q, err_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       mem_we_q, mem_we_d;
  logic       mem_re_q, mem_re_d;
  logic       sp_we_q, sp_we_d;
  logic [7:0] sp_wdata_q, sp_wdata_d;
  logic       done_q, done_d;
  logic       pc_load_q, pc_load_d;
  logic [7:0] pc_value_q, pc_value_d;
  logic [7:0] pop_hold_q, pop_hold_d;
`ifdef STACK_SAVE_FLAGS_EN
  logic [7:0] vec_q, vec_d;
  logic [3:0] fl_cap_q, fl_cap_d;
  logic       flags_load_q, flags_load_d;
  logic [3:0] flags_hold_q, flags_hold_d;
`endif

  logic       step_en, step_pop;
  logic [7:0] au_addr, au_sp_next;
  logic       au_err;
  logic       cap_pop, cap_pc;

  // Next state; a memory step happens on every entry into a WR_*/RD* state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_PUSH, OP_CALL, OP_INT: state_d = S_WR_PC;
            OP_POP, OP_RET:           state_d = S_RD;
`ifdef STACK_SAVE_FLAGS_EN
            OP_RTI:                   state_d = S_RD_FL;
`else
            OP_RTI:                   state_d = S_RD;
`endif
            default:                  state_d = S_RD_W;
          endcase
        end
      end
`ifdef STACK_SAVE_FLAGS_EN
      S_WR_PC: state_d = (op_q == OP_INT) ? S_WR_FL : S_IDLE;
      S_WR_FL: state_d = S_IDLE;
      S_RD_FL: state_d = S_RD;
`else
      S_WR_PC: state_d = S_IDLE;
`endif
      S_RD:    state_d = S_RD_W;
      S_RD_W:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef STACK_SAVE_FLAGS_EN
  assign step_pop = (state_d == S_RD) || (state_d == S_RD_FL);
  assign step_en  = step_pop || (state_d == S_WR_PC) || (state_d == S_WR_FL);
`else
  assign step_pop = (state_d == S_RD);
  assign step_en  = step_pop || (state_d == S_WR_PC);
`endif

  // Outputs are registered for the state being entered, so sp_q here is
  // already the SP left by the previous step.
  stack_addr_unit u_addr (
    .sp      (sp_q),
    .pop     (step_pop),
    .addr    (au_addr),
    .sp_next (au_sp_next),
    .err     (au_err)
  );

  assign cap_pop = (state_q == S_RD_W) && (op_q == OP_POP);
  assign cap_pc  = (state_q == S_RD_W) && ((op_q == OP_RET) || (op_q == OP_RTI));

  always_comb begin
    // NOTE: every variable is defaulted first so no path leaves it unassigned (no latches).
    op_d        = op_q;
    sp_d        = sp_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sp_wdata_d  = sp_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    sp_we_d     = 1'b0;
    done_d      = 1'b0;
    pc_load_d   = 1'b0;
    pc_value_d  = pc_value_q;
    pop_hold_d  = pop_hold_q;
`ifdef STACK_SAVE_FLAGS_EN
    vec_d        = vec_q;
    fl_cap_d     = fl_cap_q;
    flags_load_d = 1'b0;
    flags_hold_d = flags_hold_q;
`endif

    if (state_q == S_IDLE && req_valid) begin
      op_d        = req_op;
      mem_wdata_d = (req_op == OP_PUSH) ? push_data : pc_in;
`ifdef STACK_SAVE_FLAGS_EN
      vec_d       = int_vector;
      fl_cap_d    = flags_in;
`endif
    end

    if (step_en) begin
      sp_d       = au_sp_next;
      mem_addr_d = au_addr;
      sp_we_d    = 1'b1;
      sp_wdata_d = au_sp_next;
      mem_we_d   = !step_pop;
      mem_re_d   = step_pop;
      err_d      = err_q | au_err;
    end

    case (state_d)
      S_WR_PC: begin
        if (req_op == OP_CALL) begin
          done_d     = 1'b1;
          pc_load_d  = 1'b1;
          pc_value_d = target_pc;
        end else if (req_op == OP_INT) begin
`ifndef STACK_SAVE_FLAGS_EN
          done_d     = 1'b1;
          pc_load_d  = 1'b1;
          pc_value_d = int_vector;
`endif
        end else begin
          done_d = 1'b1;
        end
      end
`ifdef STACK_SAVE_FLAGS_EN
      S_WR_FL: begin
        mem_wdata_d = {4'b0000, fl_cap_q};
        done_d      = 1'b1;
        pc_load_d   = 1'b1;
        pc_value_d  = vec_q;
      end
      S_RD: flags_load_d = (state_q == S_RD_FL);
`endif
      S_RD_W: begin
        done_d    = 1'b1;
        pc_load_d = (op_d == OP_RET) || (op_d == OP_RTI);
      end
      default: ;
    endcase

    if (cap_pop) pop_hold_d = mem_rdata;
    if (cap_pc)  pc_value_d = mem_rdata;
`ifdef STACK_SAVE_FLAGS_EN
    if (flags_load_q) flags_hold_d = mem_rdata[3:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      sp_q        <= SP_RESET;
      err_q       <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      sp_we_q     <= 1'b0;
      sp_wdata_q  <= 8'h00;
      done_q      <= 1'b0;
      pc_load_q   <= 1'b0;
      pc_value_q  <= 8'h00;
      pop_hold_q  <= 8'h00;
`ifdef STACK_SAVE_FLAGS_EN
      vec_q        <= 8'h00;
      fl_cap_q     <= 4'h0;
      flags_load_q <= 1'b0;
      flags_hold_q <= 4'h0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sp_q        <= sp_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      sp_we_q     <= sp_we_d;
      sp_wdata_q  <= sp_wdata_d;
      done_q      <= done_d;
      pc_load_q   <= pc_load_d;
      pc_value_q  <= pc_value_d;
      pop_hold_q  <= pop_hold_d;
`ifdef STACK_SAVE_FLAGS_EN
      vec_q        <= vec_d;
      fl_cap_q     <= fl_cap_d;
      flags_load_q <= flags_load_d;
      flags_hold_q <= flags_hold_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign sp_we     = sp_we_q;
  assign sp_wdata  = sp_wdata_q;
  assign done      = done_q;
  assign pc_load   = pc_load_q;
  assign stack_err = err_q;

  // Read data arrives in the cycle it is consumed; the hold registers keep it afterwards.
  assign pop_data = cap_pop ? mem_rdata : pop_hold_q;
  assign pc_value = cap_pc  ? mem_rdata : pc_value_q;

`ifdef STACK_SAVE_FLAGS_EN
  assign flags_load = flags_load_q;
  assign flags_out  = flags_load_q ? mem_rdata[3:0] : flags_hold_q;
`else
  logic unused_flags;
  assign unused_flags = ^flags_in;
  assign flags_load   = 1'b0;
  assign flags_out    = 4'h0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a synchronous-read data memory model.
// Expectations follow STACK_SAVE_FLAGS_EN when the bench is built with it.
module tb_stack_sequencer;
  import stack_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_op;
  logic       req_ready;
  logic [7:0] push_data, pc_in, target_pc, int_vector;
  logic [3:0] flags_in;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata;
  logic       sp_we;
  logic [7:0] sp_wdata;
  logic       busy, done;
  logic [7:0] pop_data;
  logic       pc_load;
  logic [7:0] pc_value;
  logic       flags_load;
  logic [3:0] flags_out;
  logic       stack_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem [256];

  stack_sequencer #(.SP_RESET(8'hFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .push_data  (push_data),
    .pc_in      (pc_in),
    .target_pc  (target_pc),
    .int_vector (int_vector),
    .flags_in   (flags_in),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .sp_we      (sp_we),
    .sp_wdata   (sp_wdata),
    .busy       (busy),
    .done       (done),
    .pop_data   (pop_data),
    .pc_load    (pc_load),
    .pc_value   (pc_value),
    .flags_load (flags_load),
    .flags_out  (flags_out),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [7:0] pd,
                       input logic [7:0] pc, input logic [7:0] tgt, input logic [7:0] vec,
                       input logic [3:0] fl);
    check({tag, ".req_ready"}, 32'(req_ready), 'd1);
    req_op = op; push_data = pd; pc_in = pc; target_pc = tgt; int_vector = vec; flags_in = fl;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic exp_write(input string tag, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] spw);
    check({tag, ".mem_we"},    32'(mem_we),    'd1);
    check({tag, ".mem_re"},    32'(mem_re),    'd0);
    check({tag, ".mem_addr"},  32'(mem_addr),  32'(a));
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(d));
    check({tag, ".sp_we"},     32'(sp_we),     'd1);
    check({tag, ".sp_wdata"},  32'(sp_wdata),  32'(spw));
  endtask

  task automatic exp_read(input string tag, input logic [7:0] a, input logic [7:0] spw);
    check({tag, ".mem_re"},   32'(mem_re),   'd1);
    check({tag, ".mem_we"},   32'(mem_we),   'd0);
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'(a));
    check({tag, ".sp_we"},    32'(sp_we),    'd1);
    check({tag, ".sp_wdata"}, 32'(sp_wdata), 32'(spw));
  endtask

  task automatic exp_idle_next(input string tag);
    @(negedge clk);
    check({tag, ".ready_after"}, 32'(req_ready), 'd1);
    check({tag, ".done_after"},  32'(done),      'd0);
    check({tag, ".we_after"},    32'(mem_we),    'd0);
    check({tag, ".re_after"},    32'(mem_re),    'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0;
    push_data = 8'h00; pc_in = 8'h00; target_pc = 8'h00; int_vector = 8'h00; flags_in = 4'h0;

    repeat (2) @(negedge clk);
    check("rst.req_ready",  32'(req_ready),  'd1);
    check("rst.busy",       32'(busy),       'd0);
    check("rst.done",       32'(done),       'd0);
    check("rst.mem_we",     32'(mem_we),     'd0);
    check("rst.mem_re",     32'(mem_re),     'd0);
    check("rst.sp_we",      32'(sp_we),      'd0);
    check("rst.stack_err",  32'(stack_err),  'd0);
    check("rst.pc_load",    32'(pc_load),    'd0);
    check("rst.flags_load", 32'(flags_load), 'd0);
    check("rst.pop_data",   32'(pop_data),   'd0);
    check("rst.pc_value",   32'(pc_value),   'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // PUSH A5: write FF, SP -> FE, done in cycle 1
    issue("push", OP_PUSH, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h0);
    exp_write("push", 8'hFF, 8'hA5, 8'hFE);
    check("push.done",  32'(done),      'd1);
    check("push.busy",  32'(busy),      'd1);
    check("push.ready", 32'(req_ready), 'd0);
    exp_idle_next("push");

    // POP: read FF, SP -> FF, data with done in cycle 2
    issue("pop", OP_POP, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    exp_read("pop", 8'hFF, 8'hFF);
    check("pop.c1_done", 32'(done), 'd0);
    @(negedge clk);
    check("pop.done",     32'(done),     'd1);
    check("pop.pop_data", 32'(pop_data), 'hA5);
    check("pop.c2_re",    32'(mem_re),   'd0);
    exp_idle_next("pop");
    check("pop.pop_data_held", 32'(pop_data), 'hA5);

    // CALL 10 -> 40
    issue("call", OP_CALL, 8'h00, 8'h10, 8'h40, 8'h00, 4'h0);
    exp_write("call", 8'hFF, 8'h10, 8'hFE);
    check("call.done",     32'(done),     'd1);
    check("call.pc_load",  32'(pc_load),  'd1);
    check("call.pc_value", 32'(pc_value), 'h40);
    exp_idle_next("call");

    // RET -> 10
    issue("ret", OP_RET, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    exp_read("ret", 8'hFF, 8'hFF);
    check("ret.c1_pc_load", 32'(pc_load), 'd0);
    @(negedge clk);
    check("ret.done",     32'(done),     'd1);
    check("ret.pc_load",  32'(pc_load),  'd1);
    check("ret.pc_value", 32'(pc_value), 'h10);
    exp_idle_next("ret");

    // INT pc 22, flags 1010, vector F0
    issue("int", OP_INT, 8'h00, 8'h22, 8'h00, 8'hF0, 4'b1010);
    exp_write("int.pc", 8'hFF, 8'h22, 8'hFE);
`ifdef STACK_SAVE_FLAGS_EN
    check("int.c1_done",    32'(done),    'd0);
    check("int.c1_pc_load", 32'(pc_load), 'd0);
    @(negedge clk);
    exp_write("int.fl", 8'hFE, 8'h0A, 8'hFD);
`endif
    check("int.done",     32'(done),     'd1);
    check("int.pc_load",  32'(pc_load),  'd1);
    check("int.pc_value", 32'(pc_value), 'hF0);
    exp_idle_next("int");

    // RTI
    issue("rti", OP_RTI, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
`ifdef STACK_SAVE_FLAGS_EN
    exp_read("rti.fl", 8'hFE, 8'hFE);
    check("rti.c1_flags_load", 32'(flags_load), 'd0);
    @(negedge clk);
    exp_read("rti.pc", 8'hFF, 8'hFF);
    check("rti.flags_load", 32'(flags_load), 'd1);
    check("rti.flags_out",  32'(flags_out),  'hA);
    check("rti.c2_done",    32'(done),       'd0);
    @(negedge clk);
    check("rti.flags_held", 32'(flags_out),  'hA);
`else
    exp_read("rti", 8'hFF, 8'hFF);
    @(negedge clk);
    check("rti.flags_load", 32'(flags_load), 'd0);
    check("rti.flags_out",  32'(flags_out),  'd0);
`endif
    check("rti.done",     32'(done),     'd1);
    check("rti.pc_load",  32'(pc_load),  'd1);
    check("rti.pc_value", 32'(pc_value), 'h22);
    exp_idle_next("rti");

    // Reserved opcode: done next cycle, nothing else
    issue("rsv", 3'd6, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    check("rsv.done",    32'(done),    'd1);
    check("rsv.busy",    32'(busy),    'd1);
    check("rsv.mem_we",  32'(mem_we),  'd0);
    check("rsv.mem_re",  32'(mem_re),  'd0);
    check("rsv.sp_we",   32'(sp_we),   'd0);
    check("rsv.pc_load", 32'(pc_load), 'd0);
    exp_idle_next("rsv");
    check("rsv.stack_err", 32'(stack_err), 'd0);

    // POP on empty stack wraps to 00 and sets the sticky error
    issue("popwrap", OP_POP, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    exp_read("popwrap", 8'h00, 8'h00);
    check("popwrap.stack_err", 32'(stack_err), 'd1);
    @(negedge clk);
    check("popwrap.done",     32'(done),     'd1);
    check("popwrap.pop_data", 32'(pop_data), 'h00);
    exp_idle_next("popwrap");
    check("popwrap.err_sticky", 32'(stack_err), 'd1);

    // Reset during RTI's RD cycle
    issue("rtirst", OP_RTI, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
`ifdef STACK_SAVE_FLAGS_EN
    @(negedge clk);
`endif
    check("rtirst.in_rd", 32'(mem_re), 'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rtirst.ready",     32'(req_ready), 'd1);
    check("rtirst.busy",      32'(busy),      'd0);
    check("rtirst.done",      32'(done),      'd0);
    check("rtirst.stack_err", 32'(stack_err), 'd0);
    check("rtirst.sp_we",     32'(sp_we),     'd0);
    check("rtirst.mem_re",    32'(mem_re),    'd0);
    check("rtirst.pc_load",   32'(pc_load),   'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rtirst.done_later", 32'(done), 'd0);
    issue("pushrst", OP_PUSH, 8'hB7, 8'h00, 8'h00, 8'h00, 4'h0);
    exp_write("pushrst", 8'hFF, 8'hB7, 8'hFE);
    exp_idle_next("pushrst");

    // Held request: PUSH waits until the cycle after POP's done
    req_op = OP_POP; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_op = OP_PUSH; push_data = 8'h3C;
    exp_read("hold.pop", 8'hFF, 8'hFF);
    check("hold.c1_ready", 32'(req_ready), 'd0);
    @(negedge clk);
    check("hold.c2_done",     32'(done),      'd1);
    check("hold.c2_pop_data", 32'(pop_data),  'hB7);
    check("hold.c2_we",       32'(mem_we),    'd0);
    check("hold.c2_ready",    32'(req_ready), 'd0);
    @(negedge clk);
    check("hold.c3_ready", 32'(req_ready), 'd1);
    check("hold.c3_we",    32'(mem_we),    'd0);
    check("hold.c3_re",    32'(mem_re),    'd0);
    check("hold.c3_done",  32'(done),      'd0);
    @(negedge clk);
    req_valid = 1'b0;
    exp_write("hold.push", 8'hFF, 8'h3C, 8'hFE);
    check("hold.push_done", 32'(done), 'd1);
    exp_idle_next("hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
